// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential fixed-point divider.
package div_pkg;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned FRAC  = 4;
  localparam int unsigned ITER  = WIDTH + FRAC;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/div_if.sv
// Operand/result handshake bundle between a requester and the divider.
interface div_if;
  import div_pkg::*;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             valid;
  logic             ov;

  modport master (
    output start, A, B,
    input  Q, busy, valid, ov
  );

  modport slave (
    input  start, A, B,
    output Q, busy, valid, ov
  );

endinterface

// File: rtl/div_controller.sv
// Divider sequencing FSM: accepts start, counts iterations, strobes the datapath.
module div_controller
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic load,
  output logic shift,
  output logic done,
  output logic busy,
  output logic valid
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            cnt_q   <= CNT_W'(ITER);
            busy    <= 1'b1;
            valid   <= 1'b0;
          end
        end
        StRun: begin
          // One extra cycle at cnt_q==0 registers the saturated result.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= StDone;
            busy    <= 1'b0;
            valid   <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

  assign load  = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign shift = (state_q == StRun) && (cnt_q != '0);
  assign done  = (state_q == StRun) && (cnt_q == '0);

endmodule

// File: rtl/div_top.sv
// Radix-2 restoring unsigned divider computing floor((A << FRAC) / B), one bit per clock.
module div_top
  import div_pkg::*;
(
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  logic load;
  logic shift;
  logic done;

  logic [WIDTH-1:0] b_q;
  logic [ITER-1:0]  dvd_q;
  logic [WIDTH:0]   rem_q;
  logic [ITER-1:0]  quo_q;
  logic [WIDTH-1:0] q_q;
  logic             ov_q;

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_sub;
  logic           ge;
  logic           sat;

  div_controller u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .load  (load),
    .shift (shift),
    .done  (done),
    .busy  (bus.busy),
    .valid (bus.valid)
  );

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[ITER-1]};
    ge        = rem_shift >= {1'b0, b_q};
    rem_sub   = rem_shift - {1'b0, b_q};
    sat       = (|quo_q[ITER-1:WIDTH]) || (b_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q   <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      q_q   <= '0;
      ov_q  <= 1'b0;
    end else if (load) begin
      b_q   <= bus.B;
      dvd_q <= {bus.A, {FRAC{1'b0}}};
      rem_q <= '0;
      quo_q <= '0;
    end else if (shift) begin
      dvd_q <= {dvd_q[ITER-2:0], 1'b0};
      rem_q <= ge ? rem_sub : rem_shift;
      quo_q <= {quo_q[ITER-2:0], ge};
    end else if (done) begin
      ov_q <= sat;
      q_q  <= sat ? '1 : quo_q[WIDTH-1:0];
    end
  end

  assign bus.Q  = q_q;
  assign bus.ov = ov_q;

endmodule

// File: tb/tb_div_top.sv
// Directed self-checking bench for div_top.
module tb_div_top;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  div_if bus ();

  div_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one start pulse, then count edges until valid (bounded).
  task automatic run_op(input logic [9:0] a, input logic [9:0] b, output int lat);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 10'h155;
    bus.B = 10'h2aa;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid);
    end
    checks++;
    if (bus.ov !== 1'b0) begin
      failures++; $display("FAIL reset_ov got=%b exp=0", bus.ov);
    end
    checks++;
    if (bus.Q !== 10'd0) begin
      failures++; $display("FAIL reset_q got=%0d exp=0", bus.Q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [9:0] av [3] = '{10'd168, 10'd66, 10'd984};
    logic [9:0] bv [3] = '{10'd924, 10'd3, 10'd63};
    logic [9:0] qv [3] = '{10'd2, 10'd352, 10'd249};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], lat);
      checks++;
      if (lat != 15) begin
        failures++; $display("FAIL basic%0d_latency got=%0d exp=15", i, lat);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        failures++; $display("FAIL basic%0d_busy got=%b exp=0", i, bus.busy);
      end
      checks++;
      if (bus.ov !== 1'b0) begin
        failures++; $display("FAIL basic%0d_ov got=%b exp=0", i, bus.ov);
      end
      checks++;
      if (bus.Q !== qv[i]) begin
        failures++; $display("FAIL basic%0d_q got=%0d exp=%0d", i, bus.Q, qv[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b1 || bus.Q !== 10'd249) begin
      failures++; $display("FAIL hold got valid=%b q=%0d exp valid=1 q=249", bus.valid, bus.Q);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(10'd1023, 10'd1, lat);
    checks++;
    if (lat != 15 || bus.ov !== 1'b1 || bus.Q !== 10'd1023) begin
      failures++;
      $display("FAIL ovf got lat=%0d ov=%b q=%0d exp lat=15 ov=1 q=1023", lat, bus.ov, bus.Q);
    end
    run_op(10'd5, 10'd0, lat);
    checks++;
    if (lat != 15 || bus.ov !== 1'b1 || bus.Q !== 10'd1023) begin
      failures++;
      $display("FAIL div0 got lat=%0d ov=%b q=%0d exp lat=15 ov=1 q=1023", lat, bus.ov, bus.Q);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk);
    bus.A = 10'd66;
    bus.B = 10'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.Q !== 10'd0 || bus.ov !== 1'b0) begin
      failures++;
      $display("FAIL midrst got busy=%b valid=%b q=%0d ov=%b exp all zero",
               bus.busy, bus.valid, bus.Q, bus.ov);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(10'd66, 10'd3, lat);
    checks++;
    if (lat != 15 || bus.ov !== 1'b0 || bus.Q !== 10'd352) begin
      failures++;
      $display("FAIL after_rst got lat=%0d ov=%b q=%0d exp lat=15 ov=0 q=352", lat, bus.ov, bus.Q);
    end
  endtask

  task automatic test_start_while_busy();
    int lat = -1;
    @(negedge clk);
    bus.A = 10'd168;
    bus.B = 10'd924;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        bus.A = 10'd66;
        bus.B = 10'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (lat != 15 || bus.Q !== 10'd2 || bus.ov !== 1'b0) begin
      failures++;
      $display("FAIL busy_start got lat=%0d q=%0d ov=%b exp lat=15 q=2 ov=0", lat, bus.Q, bus.ov);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.A = 10'd66;
    bus.B = 10'd3;
    bus.start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid !== ((i == 15) || (i == 31))) begin
        failures++;
        $display("FAIL b2b_valid edge=%0d got=%b exp=%b", i, bus.valid, (i == 15) || (i == 31));
      end
    end
    checks++;
    if (bus.Q !== 10'd352) begin
      failures++; $display("FAIL b2b_q got=%0d exp=352", bus.Q);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_mid_reset();
    test_start_while_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
